// File: rtl/serial_rx.sv
// Receiver for a 32-bit SPI-like link (data_enable/sclk/sdi, MSB first).
// The link inputs are oversampled in the clk domain, and each word is delivered on a valid/ack handshake.
module serial_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             data_enable,
  input  logic             sdi,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  // state | meaning
  // IDLE  | waiting for a data_enable rising edge
  // SHIFT | collecting bits on synchronized sclk rising edges
  // TAIL  | word complete; waiting for data_enable to fall, flagging extra edges
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] de_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   de_d;
  logic                   sclk_d;
  logic                   de_s;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   de_rise;
  logic                   de_fall;
  logic                   sck_rise;
  logic [WIDTH-1:0]       shift_reg;
  logic [CW-1:0]          bit_cnt;

  // data_enable resets high so that a frame already running at reset release stays ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sync   <= '1;
      de_d      <= 1'b1;
      sclk_sync <= '0;
      sclk_d    <= 1'b0;
      sdi_sync  <= '0;
    end else begin
      de_sync   <= {de_sync[SYNC_STAGES-2:0], data_enable};
      de_d      <= de_sync[SYNC_STAGES-1];
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
    end
  end

  assign de_s     = de_sync[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign de_rise  = de_s & ~de_d;
  assign de_fall  = ~de_s & de_d;
  assign sck_rise = sclk_s & ~sclk_d;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (data_valid && data_ack)
        data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (de_rise) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A de_fall that lands together with an sclk edge wins: the frame counts as short.
          if (de_fall) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[WIDTH-2:0], sdi_s};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(WIDTH - 1)) begin
              state <= TAIL;
              if (!data_valid || data_ack) begin
                data_out   <= {shift_reg[WIDTH-2:0], sdi_s};
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        TAIL: begin
          if (sck_rise)
            frame_err <= 1'b1;
          if (de_fall)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: directed link scenarios plus random frames.
// Each expected word is queued when its frame is sent, and an ack-driving monitor pops and compares each word as it is accepted.
module tb_serial_rx;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sclk = 1'b0;
  logic             data_enable = 1'b0;
  logic             sdi = 1'b0;
  logic             data_ack = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  int               checks = 0;
  int               errors = 0;
  int               err_cnt = 0;
  int               ovr_cnt = 0;
  int               exp_err = 0;
  int               exp_ovr = 0;
  bit               auto_ack = 1'b1;
  logic [WIDTH-1:0] exp_q[$];

  serial_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .data_enable(data_enable),
    .sdi        (sdi),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse counters: a pulse held longer than one clk is counted more than once.
  always @(negedge clk) begin
    if (rst_n && frame_err === 1'b1) err_cnt++;
    if (rst_n && overrun === 1'b1) ovr_cnt++;
  end

  // Consumer and monitor: a word is compared at the moment the ack that accepts it is driven.
  initial begin
    forever begin
      @(negedge clk);
      data_ack = auto_ack && (data_valid === 1'b1);
      if (data_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_out: got %0h expected no word at %0t", data_out, $time);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
        end
      end
    end
  end

  // The link sender changes sdi and data_enable on sclk falling edges; sclk runs at 1/8 of clk.
  task automatic send_frame(input logic [39:0] stream, input int nbits, input int rst_at,
                            input bit lat_chk, input bit ack_last);
    int idx;
    @(negedge clk);
    data_enable = 1'b1;
    sdi = stream[39];
    #40;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      #13;
      if (ack_last && i == nbits - 1) auto_ack = 1'b1;
      #7;
      if (lat_chk && i == nbits - 1) chk("valid_latency_early", data_valid, 0);
      #8;
      if ((lat_chk || ack_last) && i == nbits - 1) chk("valid_after_last_bit", data_valid, 1);
      if (i == 16) chk("busy_mid_frame", busy, (rst_at < 0) || (i < rst_at));
      #12;
      sclk = 1'b0;
      idx = 38 - i;
      sdi = (idx >= 0) ? stream[idx] : 1'b0;
      if (i == rst_at) begin
        #10 rst_n = 1'b0;
        #1 chk("busy_in_reset", busy, 0);
        chk("valid_in_reset", data_valid, 0);
        #9 rst_n = 1'b1;
        #20;
      end else begin
        #40;
      end
    end
    data_enable = 1'b0;
    sdi = 1'b0;
    #120;
    chk("busy_idle_after_frame", busy, 0);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_frame_err_count"}, err_cnt, exp_err);
    chk({tag, "_overrun_count"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [39:0] stream;
    int          kind;
    int          nb;

    #1;
    chk("reset_data_out", data_out, 0);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: plain frame, latency check on the last edge
    exp_q.push_back(32'hA5C30F81);
    send_frame({32'hA5C30F81, 8'h00}, 32, -1, 1'b1, 1'b0);
    checkpoint("t1");

    // 2: second word completes while the first is unread
    auto_ack = 1'b0;
    exp_q.push_back(32'h12345678);
    send_frame({32'h12345678, 8'h00}, 32, -1, 1'b0, 1'b0);
    send_frame({32'hDEADBEEF, 8'h00}, 32, -1, 1'b0, 1'b0);
    exp_ovr += 1;
    checkpoint("t2");
    chk("t2_valid_held", data_valid, 1);
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("t2_valid_after_ack", data_valid, 0);

    // 3: short frame, then a good one
    send_frame({32'hFFFFFFFF, 8'hFF}, 20, -1, 1'b0, 1'b0);
    exp_err += 1;
    chk("t3_no_valid", data_valid, 0);
    exp_q.push_back(32'h00000001);
    send_frame({32'h00000001, 8'h00}, 32, -1, 1'b0, 1'b0);
    checkpoint("t3");

    // 4: one extra sclk edge
    exp_q.push_back(32'h80000001);
    send_frame({32'h80000001, 8'h80}, 33, -1, 1'b0, 1'b0);
    exp_err += 1;
    checkpoint("t4");

    // 5: reset in mid-frame with data_enable still high
    send_frame({32'h55AA55AA, 8'h00}, 32, 10, 1'b0, 1'b0);
    chk("t5_no_valid", data_valid, 0);
    checkpoint("t5");
    exp_q.push_back(32'hCAFEF00D);
    send_frame({32'hCAFEF00D, 8'h00}, 32, -1, 1'b0, 1'b0);
    checkpoint("t5b");

    // 6: ack of the old word coincides with completion of the new one
    auto_ack = 1'b0;
    exp_q.push_back(32'h0BADC0DE);
    send_frame({32'h0BADC0DE, 8'h00}, 32, -1, 1'b0, 1'b0);
    exp_q.push_back(32'h600DF00D);
    send_frame({32'h600DF00D, 8'h00}, 32, -1, 1'b0, 1'b1);
    checkpoint("t6");

    // random frames: full, short, or with 1..3 extra edges
    auto_ack = 1'b1;
    for (int f = 0; f < 16; f++) begin
      stream = {$urandom(), 8'($urandom())};
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        nb = int'($urandom_range(1, 31));
        exp_err += 1;
      end else if (kind < 4) begin
        nb = 32 + int'($urandom_range(1, 3));
        exp_err += nb - 32;
        exp_q.push_back(stream[39:8]);
      end else begin
        nb = 32;
        exp_q.push_back(stream[39:8]);
      end
      send_frame(stream, nb, -1, 1'b0, 1'b0);
    end
    checkpoint("rand");

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", data_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
